// File: rtl/gpo_pulse.sv
// GPO slot core: W output pins from a data register with set/clear/toggle writes plus a shared one-shot pulse engine.
// Optional macro GPO_READBACK_EN enables the register read mux; without it rd_data is constant 0.
module gpo_pulse #(
  parameter int             W     = 8,
  parameter int             DUR_W = 16,
  parameter logic [W-1:0]   INIT  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic [W-1:0]      dout
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     pmask_q, pmask_d;
  logic [DUR_W-1:0] pdur_q, pdur_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;

  logic             wr_en;
  logic [2:0]       sel;
  logic [W-1:0]     wmask;
  logic             trig_ok;
  logic             busy;

  assign wr_en   = cs & write;
  assign sel     = addr[2:0];
  assign wmask   = wr_data[W-1:0];
  assign trig_ok = wr_en && (sel == 3'd5) && (|wmask) && (|pdur_q);
  assign busy    = (state_q == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= INIT;
      pmask_q <= '0;
      pdur_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pmask_q <= pmask_d;
      pdur_q  <= pdur_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    data_d = data_q;
    pdur_d = pdur_q;
    if (wr_en) begin
      case (sel)
        3'd0:    data_d = wmask;
        3'd1:    data_d = data_q | wmask;
        3'd2:    data_d = data_q & ~wmask;
        3'd3:    data_d = data_q ^ wmask;
        3'd4:    pdur_d = wr_data[DUR_W-1:0];
        default: ;
      endcase
    end
  end

  // A valid retrigger reloads the counter even on the cycle the pulse would expire.
  always_comb begin
    state_d = state_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trig_ok) begin
          pmask_d = wmask;
          cnt_d   = pdur_q;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (trig_ok) begin
          pmask_d = pmask_q | wmask;
          cnt_d   = pdur_q;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) begin
            state_d = IDLE;
            pmask_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_dout
    assign dout[gi] = data_q[gi] | (busy & pmask_q[gi]);
  end

`ifdef GPO_READBACK_EN
  always_comb begin
    rd_data = '0;
    case (sel)
      3'd0:    rd_data = 32'(data_q);
      3'd4:    rd_data = 32'(pdur_q);
      3'd5:    rd_data = 32'(pmask_q);
      3'd6:    rd_data = {31'b0, busy};
      default: rd_data = '0;
    endcase
  end
`else
  assign rd_data = '0;
`endif

  // Bus inputs that no register decode consumes.
  logic unused_bus;
  assign unused_bus = ^{read, addr[4:3], wr_data};

endmodule
